data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU data-memory interface: accepts the core's address, write data, write enable and byte-lane mask, and returns read data in the same cycle, as the single-cycle core requires. It contains the data RAM and a memory-mapped machine timer (64-bit `mtime`/`mtimecmp`) whose sticky interrupt output drives the core's interrupt request line. It sits between the CPU's data port and the top level, alongside the instruction memory.

## Interface
- `RAM_WORDS`, 1024: number of 32-bit RAM words; power of two.
- `TIMER_BASE`, 32'hFFFF_0000: base address of the timer register block; 32-byte aligned.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled only at the rising edge of `clk`.
- `memAddr`  in  32  byte address from the CPU.
- `memWriteData`  in  32  write data, already shifted into its byte lanes.
- `memWr`  in  1  write enable.
- `wrMask`  in  4  byte-lane enables; bit n selects bits [8n+7:8n].
- `memReadData`  out  32  combinational read data for `memAddr`.
- `irq`  out  1  timer interrupt request, level, equal to the pending bit.

## Operation
- Address decode uses the full 32-bit `memAddr`. `memAddr[1:0]` is ignored for word selection.
  - RAM region: 0 to RAM_WORDS*4-1. Word index is `memAddr[log2(RAM_WORDS)+1:2]`.
  - Timer region: TIMER_BASE+0x00 `mtime[31:0]`, +0x04 `mtime[63:32]`, +0x08 `mtimecmp[31:0]`, +0x0C `mtimecmp[63:32]`, +0x10 `ctrl`.
  - `ctrl` bit0 is `enable` (RW). Bit1 is `pending` (read, write-1-to-clear). Bits 31:2 read 0.
  - Any other address: reads return 0 and writes are ignored. Timer offsets 0x14 to 0x1C are in this category.
- Reads are asynchronous (combinational) for both regions. A write does not affect `memReadData` until after the clock edge that performs it.
- Writes occur at the rising edge when `memWr=1`. Only lanes with `wrMask[n]=1` are updated; this applies to RAM and to timer registers alike.
  - `wrMask=0000` with `memWr=1` is a no-op.
  - For `ctrl`, lane 0 carries both bits. A write with lane 0 clear does not change `enable` and does not clear `pending`.
- `mtime` increments by 1 per cycle while `enable=1`. It wraps from 2^64-1 to 0 with no flag.
  - A write to either `mtime` word in a cycle replaces that word with the written lanes. No increment occurs in that cycle; the whole 64-bit value holds and the write applies.
- The compare is unsigned 64-bit: `hit = enable & (mtime >= mtimecmp)`. Both operands are the current register values, before any update at this edge.
- `pending` is set at an edge where `hit=1` and is sticky. It is cleared by a write of 1 to `ctrl` bit1 with `wrMask[0]=1`. If set and clear occur at the same edge, set wins.
- Clearing `enable` stops counting and stops new sets. It does not clear `pending`.
- RAM contents are not affected by reset and are undefined after power-up.

## Timing
- Reset: when `reset=0` at an edge, the next-state values are:
  - `mtime` = 0
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
  - `enable` = 0, `pending` = 0, so `irq` = 0.
  - Writes presented during reset are ignored.
  - Reset asserted mid-count takes effect at the first edge where it is sampled low.
- Read latency is 0 cycles. Write latency is 1 edge.
- `irq` rises one cycle after the cycle in which `mtime >= mtimecmp` first holds with `enable=1`.
- Updating the two 32-bit words of `mtimecmp` is not atomic. Software writes the high word first to 32'hFFFF_FFFF to avoid a spurious hit; the hardware provides no protection.
- An `mtime` word read returns the value before the edge; there is no snapshot of the other word.

## Test plan
- **RAM lanes:** write 32'hAABBCCDD to address 0x10 with mask 1111, then 32'h0000_EE00 with mask 0010 -> read of 0x10 returns 32'hAABBEEDD; read of 0x13 returns the same word.
- **Timer hit:**
  - Setup: set `mtimecmp` = {0, 5}, write `ctrl` = 1 at cycle 0.
  - Expect: `mtime` reads 0,1,2,... on successive cycles; `irq` rises exactly one cycle after `mtime` = 5; `irq` stays high with counting continuing.
- **Set-vs-clear collision:** with `hit` held true, write `ctrl` = 32'h3 -> `pending` (and `irq`) remains 1. Then set `enable` = 0 and write 32'h2 -> `irq` = 0 at the next cycle.
- **Wrap and write precedence:**
  - Write `mtime` hi = 32'hFFFF_FFFF and lo = 32'hFFFF_FFFE with `enable` = 1.
  - Expect: in the write cycle `mtime` holds (no increment), then reads …FFFE, …FFFF, 0, 1.
  - With `mtimecmp` all-ones, `irq` rises one cycle after `mtime` = 2^64-1 and stays set after the wrap.
- **Reset mid-operation:** while counting with `irq` = 1, drive `reset` = 0 for one edge concurrently with a RAM-region-invisible timer write -> `mtime` = 0, `mtimecmp` = all-ones, `ctrl` reads 0, `irq` = 0; the concurrent timer write has no effect.
- **Unmapped access:** write to TIMER_BASE+0x14 and to address RAM_WORDS*4 -> no register or RAM changes; both addresses read 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus a memory-mapped 64-bit machine timer.
// Reads are combinational; writes and timer state update at the rising edge.
module data_mem_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        memWr,
  input  logic [3:0]  wrMask,
  output logic [31:0] memReadData,
  output logic        irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [2:0] OFF_TLO = 3'd0;
  localparam logic [2:0] OFF_THI = 3'd1;
  localparam logic [2:0] OFF_CLO = 3'd2;
  localparam logic [2:0] OFF_CHI = 3'd3;
  localparam logic [2:0] OFF_CTL = 3'd4;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtcmp_q, mtcmp_d;
  logic          en_q, en_d;
  logic          pend_q, pend_d;

  logic          ram_sel;
  logic          tmr_sel;
  logic [2:0]    tmr_off;
  logic [AW-1:0] ram_idx;
  logic          wr_en;
  logic          wr_tlo, wr_thi, wr_clo, wr_chi, wr_ctl;
  logic          hit;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (mask[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign ram_sel = memAddr < RAM_BYTES;
  assign tmr_sel = memAddr[31:5] == TIMER_BASE[31:5];
  assign tmr_off = memAddr[4:2];
  assign ram_idx = memAddr[AW+1:2];
  // Writes are blocked while reset is asserted, RAM included.
  assign wr_en   = memWr & reset & (|wrMask);

  assign wr_tlo = wr_en & tmr_sel & (tmr_off == OFF_TLO);
  assign wr_thi = wr_en & tmr_sel & (tmr_off == OFF_THI);
  assign wr_clo = wr_en & tmr_sel & (tmr_off == OFF_CLO);
  assign wr_chi = wr_en & tmr_sel & (tmr_off == OFF_CHI);
  assign wr_ctl = wr_en & tmr_sel & (tmr_off == OFF_CTL) & wrMask[0];

  assign hit = en_q & (mtime_q >= mtcmp_q);
  assign irq = pend_q;

  always_comb begin
    mtime_d = mtime_q;
    mtcmp_d = mtcmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    // A write to either mtime word freezes the count for that edge.
    if (wr_tlo | wr_thi) begin
      if (wr_tlo) mtime_d[31:0]  = merge(mtime_q[31:0], memWriteData, wrMask);
      if (wr_thi) mtime_d[63:32] = merge(mtime_q[63:32], memWriteData, wrMask);
    end else if (en_q) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_clo) mtcmp_d[31:0]  = merge(mtcmp_q[31:0], memWriteData, wrMask);
    if (wr_chi) mtcmp_d[63:32] = merge(mtcmp_q[63:32], memWriteData, wrMask);
    if (wr_ctl) begin
      en_d = memWriteData[0];
      if (memWriteData[1]) pend_d = 1'b0;
    end
    if (hit) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q <= 64'd0;
      mtcmp_q <= '1;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      mtcmp_q <= mtcmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en & ram_sel)
      for (int i = 0; i < 4; i++)
        if (wrMask[i]) ram_q[ram_idx][8*i +: 8] <= memWriteData[8*i +: 8];
  end

  always_comb begin
    memReadData = 32'd0;
    if (ram_sel) begin
      memReadData = ram_q[ram_idx];
    end else if (tmr_sel) begin
      case (tmr_off)
        OFF_TLO: memReadData = mtime_q[31:0];
        OFF_THI: memReadData = mtime_q[63:32];
        OFF_CLO: memReadData = mtcmp_q[31:0];
        OFF_CHI: memReadData = mtcmp_q[63:32];
        OFF_CTL: memReadData = {30'd0, pend_q, en_q};
        default: memReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a
// transaction-level model of RAM bytes and timer registers.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam logic [31:0] TB_BASE    = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BYTES  = RAM_WORDS * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memWr;
  logic [3:0]  wrMask;
  logic [31:0] memReadData;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_byte [RAM_BYTES];
  bit          m_bv   [RAM_BYTES];
  logic [63:0] m_time, m_cmp;
  bit          m_en, m_pend;

  data_mem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .TIMER_BASE(TB_BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memWr       (memWr),
    .wrMask      (wrMask),
    .memReadData (memReadData),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_timer(input logic [31:0] a);
    return (a >= TB_BASE) && ((a - TB_BASE) < 32'd20);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [31:0] base;
    known = 1'b1;
    if (a < RAM_BYTES) begin
      base = a & ~32'd3;
      m_read = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (!m_bv[base + i]) known = 1'b0;
        m_read[8*i +: 8] = m_byte[base + i];
      end
    end else if (in_timer(a)) begin
      case ((a - TB_BASE) / 4)
        0: m_read = m_time[31:0];
        1: m_read = m_time[63:32];
        2: m_read = m_cmp[31:0];
        3: m_read = m_cmp[63:32];
        default: m_read = {30'd0, m_pend, m_en};
      endcase
    end else begin
      m_read = 32'd0;
    end
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_time = 64'd0;
    m_cmp  = '1;
    m_en   = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic m_step(input logic [31:0] a, input logic [31:0] wd,
                        input bit wr, input logic [3:0] mk, input bit rst_n);
    bit          hit, tw, clr, nen;
    logic [63:0] nt, nc;
    logic [31:0] base;
    if (!rst_n) begin
      m_reset();
      return;
    end
    hit = m_en && (m_time >= m_cmp);
    tw = 0; clr = 0; nen = m_en;
    nt = m_time; nc = m_cmp;
    if (wr && mk != 4'd0) begin
      if (a < RAM_BYTES) begin
        base = a & ~32'd3;
        for (int i = 0; i < 4; i++)
          if (mk[i]) begin
            m_byte[base + i] = wd[8*i +: 8];
            m_bv[base + i]   = 1'b1;
          end
      end else if (in_timer(a)) begin
        case ((a - TB_BASE) / 4)
          0: begin nt[31:0]  = lanes(m_time[31:0], wd, mk);  tw = 1; end
          1: begin nt[63:32] = lanes(m_time[63:32], wd, mk); tw = 1; end
          2: nc[31:0]  = lanes(m_cmp[31:0], wd, mk);
          3: nc[63:32] = lanes(m_cmp[63:32], wd, mk);
          default: if (mk[0]) begin nen = wd[0]; clr = wd[1]; end
        endcase
      end
    end
    if (!tw && m_en) nt = m_time + 64'd1;
    m_time = nt;
    m_cmp  = nc;
    m_en   = nen;
    m_pend = hit || (m_pend && !clr);
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                     input bit wr, input logic [3:0] mk, input bit rst_n = 1'b1);
    logic [31:0] exp;
    bit          known;
    memAddr = a; memWriteData = wd; memWr = wr; wrMask = mk; reset = rst_n;
    #1;
    exp = m_read(a, known);
    if (known) check("rd_model", memReadData, exp);
    check("irq_model", {31'd0, irq}, {31'd0, m_pend});
    @(posedge clk);
    m_step(a, wd, wr, mk, rst_n);
    #1;
    reset = 1'b1; memWr = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memAddr = a; memWr = 1'b0; reset = 1'b1;
    #1;
    check(tag, memReadData, exp);
  endtask

  task automatic chk_irq(input string tag, input bit exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < int'(RAM_BYTES); i++) m_bv[i] = 1'b0;
    reset = 1'b0; memAddr = 32'd0; memWriteData = 32'd0;
    memWr = 1'b0; wrMask = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    probe("rst_mtime_lo", TB_BASE + 32'h00, 32'd0);
    probe("rst_mtime_hi", TB_BASE + 32'h04, 32'd0);
    probe("rst_cmp_hi",   TB_BASE + 32'h0C, 32'hFFFF_FFFF);
    probe("rst_ctrl",     TB_BASE + 32'h10, 32'd0);
    chk_irq("rst_irq", 1'b0);

    cyc(32'h10, 32'hAABB_CCDD, 1, 4'b1111);
    cyc(32'h10, 32'h0000_EE00, 1, 4'b0010);
    probe("ram_lane",   32'h10, 32'hAABB_EEDD);
    probe("ram_lane13", 32'h13, 32'hAABB_EEDD);
    cyc(32'h10, 32'h1111_1111, 1, 4'b0000);
    probe("ram_mask0", 32'h10, 32'hAABB_EEDD);

    cyc(TB_BASE + 32'h0C, 32'd0, 1, 4'hF);
    cyc(TB_BASE + 32'h08, 32'd5, 1, 4'hF);
    cyc(TB_BASE + 32'h10, 32'd1, 1, 4'hF);
    for (int k = 0; k < 10; k++) begin
      probe("hit_mtime", TB_BASE, 32'(k));
      chk_irq("hit_irq", k >= 6);
      cyc(TB_BASE, 32'd0, 0, 4'h0);
    end

    cyc(TB_BASE + 32'h10, 32'h3, 1, 4'h1);
    chk_irq("coll_irq", 1'b1);
    cyc(TB_BASE + 32'h10, 32'h0, 1, 4'h1);
    chk_irq("dis_irq_kept", 1'b1);
    cyc(TB_BASE + 32'h10, 32'h2, 1, 4'h1);
    chk_irq("clr_irq", 1'b0);
    probe("clr_ctrl", TB_BASE + 32'h10, 32'd0);

    cyc(TB_BASE + 32'h0C, 32'hFFFF_FFFF, 1, 4'hF);
    cyc(TB_BASE + 32'h08, 32'hFFFF_FFFF, 1, 4'hF);
    cyc(TB_BASE + 32'h10, 32'h1, 1, 4'h1);
    cyc(TB_BASE + 32'h04, 32'hFFFF_FFFF, 1, 4'hF);
    cyc(TB_BASE + 32'h00, 32'hFFFF_FFFE, 1, 4'hF);
    probe("wrap0_lo", TB_BASE, 32'hFFFF_FFFE);
    probe("wrap0_hi", TB_BASE + 4, 32'hFFFF_FFFF);
    chk_irq("wrap0_irq", 1'b0);
    cyc(TB_BASE, 32'd0, 0, 4'h0);
    probe("wrap1_lo", TB_BASE, 32'hFFFF_FFFF);
    chk_irq("wrap1_irq", 1'b0);
    cyc(TB_BASE, 32'd0, 0, 4'h0);
    probe("wrap2_lo", TB_BASE, 32'h0);
    probe("wrap2_hi", TB_BASE + 4, 32'h0);
    chk_irq("wrap2_irq", 1'b1);
    cyc(TB_BASE, 32'd0, 0, 4'h0);
    probe("wrap3_lo", TB_BASE, 32'h1);
    chk_irq("wrap3_irq", 1'b1);

    cyc(TB_BASE + 32'h00, 32'h1234, 1, 4'hF, 1'b0);
    probe("mrst_mtime", TB_BASE,        32'd0);
    probe("mrst_cmplo", TB_BASE + 8,    32'hFFFF_FFFF);
    probe("mrst_cmphi", TB_BASE + 12,   32'hFFFF_FFFF);
    probe("mrst_ctrl",  TB_BASE + 16,   32'd0);
    chk_irq("mrst_irq", 1'b0);

    cyc(TB_BASE + 32'h14, 32'hDEAD_BEEF, 1, 4'hF);
    cyc(RAM_BYTES, 32'hCAFE_F00D, 1, 4'hF);
    probe("unm_t14", TB_BASE + 32'h14, 32'd0);
    probe("unm_ram", RAM_BYTES, 32'd0);
    probe("unm_r0",  32'h10, 32'hAABB_EEDD);
    probe("unm_cmp", TB_BASE + 8, 32'hFFFF_FFFF);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 6))
        0, 1: a = $urandom_range(0, 63);
        2, 3: a = TB_BASE + $urandom_range(0, 31);
        4:    a = TB_BASE + 32'h10;
        5:    a = RAM_BYTES + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      cyc(a, (a - TB_BASE < 32'd16) ? $urandom_range(0, 40) : $urandom,
          $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
          $urandom_range(0, 40) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
